fetch_unit: RTL and testbench

//  Parametrised instruction fetch stage with a prefetch queue. It generates

---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory and decode handshake bundle for fetch_unit
interface fetch_unit_if #(
    parameter int XLEN  = 32,
    parameter int PCLEN = 32
);
    logic             imem_req_valid;
    logic             imem_req_ready;
    logic [PCLEN-1:0] imem_req_addr;
    logic             imem_resp_valid;
    logic [XLEN-1:0]  imem_resp_data;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_instr;
    logic [PCLEN-1:0] out_pc;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential instruction fetch with prefetch FIFO and redirect flush
module fetch_unit #(
    parameter int               XLEN     = 32,
    parameter int               PCLEN    = 32,
    parameter int               DEPTH    = 4,
    parameter int               MAX_OUT  = 4,
    parameter logic [PCLEN-1:0] RESET_PC = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    fetch_unit_if.master                       bus,
    input  logic                               redirect_valid,
    input  logic [PCLEN-1:0]                   redirect_pc,
    output logic [$clog2(MAX_OUT+1)-1:0]       stale_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(MAX_OUT + 1);
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

    state_t           state, state_next;
    logic [SW-1:0]    stale_next;
    logic [SW-1:0]    outstanding;
    logic [PCLEN-1:0] pc;

    logic [CW-1:0]    fifo_count;
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [XLEN-1:0]  instr_mem [DEPTH];
    logic [PCLEN-1:0] pc_mem    [DEPTH];

    logic [PCLEN-1:0] tag_mem   [MAX_OUT];
    logic [TW-1:0]    tag_rd, tag_wr;

    logic             req_ok, req_fire, enq, deq;
    logic [CW:0]      credit_sum;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUT - 1)) ? '0 : p + TW'(1);
    endfunction

    // Requests are only issued while every in-flight response is sure of a FIFO slot.
    always_comb begin
        state_next = state;
        stale_next = stale_cnt;
        credit_sum = {1'b0, fifo_count} + (CW+1)'(outstanding);
        req_ok     = (state == RUN) && !redirect_valid &&
                     (outstanding < SW'(MAX_OUT)) && (credit_sum < (CW+1)'(DEPTH));
        if (redirect_valid) begin
            stale_next = stale_cnt + outstanding;
            if (bus.imem_resp_valid && (stale_next != '0))
                stale_next = stale_next - SW'(1);
            state_next = (stale_next != '0) ? DRAIN : RUN;
        end else if ((state == DRAIN) && bus.imem_resp_valid) begin
            stale_next = stale_cnt - SW'(1);
            if (stale_next == '0)
                state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            stale_cnt <= '0;
        end else begin
            state     <= state_next;
            stale_cnt <= stale_next;
        end
    end

    assign bus.imem_req_valid = req_ok && !reset;
    assign bus.imem_req_addr  = pc;
    assign bus.out_valid      = (fifo_count != '0) && !reset;
    assign bus.out_instr      = reset ? '0 : instr_mem[rd_ptr];
    assign bus.out_pc         = reset ? '0 : pc_mem[rd_ptr];

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign enq      = bus.imem_resp_valid && (stale_cnt == '0) && !redirect_valid;
    assign deq      = bus.out_valid && bus.out_ready && !redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC & ~PCLEN'(3);
            outstanding <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
        end else if (redirect_valid) begin
            pc          <= redirect_pc & ~PCLEN'(3);
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= rd_ptr;
            tag_rd      <= '0;
            tag_wr      <= '0;
        end else begin
            if (req_fire) begin
                pc     <= pc + PCLEN'(4);
                tag_wr <= tag_inc(tag_wr);
            end
            if (enq) begin
                wr_ptr <= wr_ptr + AW'(1);
                tag_rd <= tag_inc(tag_rd);
            end
            if (deq)
                rd_ptr <= rd_ptr + AW'(1);
            case ({req_fire, enq})
                2'b10:   outstanding <= outstanding + SW'(1);
                2'b01:   outstanding <= outstanding - SW'(1);
                default: ;
            endcase
            case ({enq, deq})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        if (req_fire)
            tag_mem[tag_wr] <= pc;
        if (enq) begin
            instr_mem[wr_ptr] <= bus.imem_resp_data;
            pc_mem[wr_ptr]    <= tag_mem[tag_rd];
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 4;

    logic        clk;
    logic        reset;
    logic        redirect_a;
    logic [31:0] rpc_a;
    logic [2:0]  stale_a;

    logic        reset_b;
    logic        redirect_b;
    logic [7:0]  rpc_b;
    logic [2:0]  stale_b;

    fetch_unit_if #(.XLEN(32), .PCLEN(32)) bus_a ();
    fetch_unit_if #(.XLEN(32), .PCLEN(8))  bus_b ();

    fetch_unit #(.XLEN(32), .PCLEN(32), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .bus(bus_a),
        .redirect_valid(redirect_a), .redirect_pc(rpc_a), .stale_cnt(stale_a)
    );

    fetch_unit #(.XLEN(32), .PCLEN(8), .DEPTH(4), .MAX_OUT(4), .RESET_PC(8'hF8)) dut_b (
        .clk(clk), .reset(reset_b), .bus(bus_b),
        .redirect_valid(redirect_b), .redirect_pc(rpc_b), .stale_cnt(stale_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mem_req_t;
    typedef struct { bit ord; bit exp_req; logic [31:0] exp_addr; bit exp_ov; logic [31:0] exp_pc; } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    mem_req_t    memq[$];
    int          last_due;
    int          rdy_pct, ord_pct, lat_lo, lat_hi;

    logic [31:0] m_fifo[$];
    logic [31:0] m_outq[$];
    logic [31:0] m_pc;
    int          m_stale;

    bit          cur_rdr, exp_req, exp_ov;
    logic [31:0] cur_rpc;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired at cyc=%0d", name, cyc);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_a = 1'b0;
        bus_a.imem_req_ready = 1'b0;
        bus_a.imem_resp_valid = 1'b0;
        bus_a.out_ready = 1'b0;
        #3;
        chk("rst_req_valid", 32'(bus_a.imem_req_valid), 0);
        chk("rst_out_valid", 32'(bus_a.out_valid), 0);
        chk("rst_out_instr", bus_a.out_instr, 0);
        chk("rst_out_pc", bus_a.out_pc, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        memq.delete();
        last_due = -1;
        m_fifo.delete();
        m_outq.delete();
        m_stale = 0;
        m_pc = 32'h0;
        cyc = 0;
    endtask

    // Drive one cycle of inputs, then compare DUT outputs with the queue model.
    task automatic begin_cycle(input bit rdr, input logic [31:0] rpc);
        cur_rdr = rdr;
        cur_rpc = rpc;
        redirect_a = rdr;
        rpc_a = rpc;
        bus_a.imem_req_ready = ($urandom_range(99) < rdy_pct);
        bus_a.out_ready = ($urandom_range(99) < ord_pct);
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            bus_a.imem_resp_valid = 1'b1;
            bus_a.imem_resp_data = instr_of(memq[0].addr);
        end else begin
            bus_a.imem_resp_valid = 1'b0;
            bus_a.imem_resp_data = $urandom;
        end
        #3;
        exp_req = !rdr && m_stale == 0 && m_outq.size() < MAX_OUT &&
                  (m_fifo.size() + m_outq.size()) < DEPTH;
        exp_ov = m_fifo.size() > 0;
        chk("req_valid", 32'(bus_a.imem_req_valid), 32'(exp_req));
        if (exp_req) chk("req_addr", bus_a.imem_req_addr, m_pc);
        chk("out_valid", 32'(bus_a.out_valid), 32'(exp_ov));
        if (exp_ov) begin
            chk("out_pc", bus_a.out_pc, m_fifo[0]);
            chk("out_instr", bus_a.out_instr, instr_of(m_fifo[0]));
        end
        chk("stale_cnt", 32'(stale_a), m_stale);
    endtask

    task automatic end_cycle();
        mem_req_t r;
        int n;
        bit resp;
        resp = bus_a.imem_resp_valid;
        if (resp) void'(memq.pop_front());
        if (bus_a.imem_req_valid && bus_a.imem_req_ready) begin
            r.addr = bus_a.imem_req_addr;
            r.due = cyc + $urandom_range(lat_hi, lat_lo);
            if (r.due <= last_due) r.due = last_due + 1;
            last_due = r.due;
            memq.push_back(r);
        end
        if (cur_rdr) begin
            n = m_stale + m_outq.size();
            if (resp && n > 0) n--;
            m_stale = n;
            m_fifo.delete();
            m_outq.delete();
            m_pc = cur_rpc & ~32'h3;
        end else begin
            if (exp_ov && bus_a.out_ready) void'(m_fifo.pop_front());
            if (resp) begin
                if (m_stale > 0) m_stale--;
                else if (m_outq.size() > 0) m_fifo.push_back(m_outq.pop_front());
            end
            if (exp_req && bus_a.imem_req_ready) begin
                m_outq.push_back(m_pc);
                m_pc = m_pc + 32'h4;
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    initial begin
        vec_t        t1[8];
        logic [7:0]  b_exp[4];
        logic [31:0] exp_pc, tgt;
        int          got;
        bit          seen, fired_prev;
        logic [7:0]  prev_addr;

        t1[0] = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
        t1[1] = '{1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
        t1[2] = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd0};
        t1[3] = '{1'b1, 1'b1, 32'd12, 1'b1, 32'd4};
        t1[4] = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd8};
        t1[5] = '{1'b0, 1'b1, 32'd20, 1'b1, 32'd12};
        t1[6] = '{1'b1, 1'b1, 32'd24, 1'b1, 32'd12};
        t1[7] = '{1'b1, 1'b1, 32'd28, 1'b1, 32'd16};
        b_exp[0] = 8'hF8; b_exp[1] = 8'hFC; b_exp[2] = 8'h00; b_exp[3] = 8'h04;

        reset = 1'b1; redirect_a = 1'b0; rpc_a = '0;
        bus_a.imem_req_ready = 0; bus_a.imem_resp_valid = 0; bus_a.imem_resp_data = 0; bus_a.out_ready = 0;
        reset_b = 1'b1; redirect_b = 1'b0; rpc_b = '0;
        bus_b.imem_req_ready = 0; bus_b.imem_resp_valid = 0; bus_b.imem_resp_data = 0; bus_b.out_ready = 0;
        @(posedge clk); #1;

        // Streaming fetch from reset, with one decode stall.
        do_reset();
        rdy_pct = 100; lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 8; i++) begin
            ord_pct = t1[i].ord ? 100 : 0;
            begin_cycle(1'b0, 32'h0);
            chk("t1_req", 32'(bus_a.imem_req_valid), 32'(t1[i].exp_req));
            chk("t1_addr", bus_a.imem_req_addr, t1[i].exp_addr);
            chk("t1_ov", 32'(bus_a.out_valid), 32'(t1[i].exp_ov));
            if (t1[i].exp_ov) chk("t1_pc", bus_a.out_pc, t1[i].exp_pc);
            end_cycle();
        end

        // Decode stalled: FIFO fills, requests stop, then in-order drain.
        do_reset();
        rdy_pct = 100; ord_pct = 0; lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 8; i++) begin begin_cycle(1'b0, 32'h0); end_cycle(); end
        begin_cycle(1'b0, 32'h0);
        chk("t2_full_req", 32'(bus_a.imem_req_valid), 0);
        chk("t2_full_ov", 32'(bus_a.out_valid), 1);
        chk("t2_head", bus_a.out_pc, 32'h0);
        end_cycle();
        ord_pct = 100; exp_pc = 0; got = 0;
        for (int i = 0; i < 40 && got < 12; i++) begin
            begin_cycle(1'b0, 32'h0);
            if (bus_a.out_valid) begin
                chk("t2_drain_pc", bus_a.out_pc, exp_pc);
                exp_pc += 4; got++;
            end
            end_cycle();
        end
        if (got < 12) timeout_fail("t2_drain");

        // Redirect with three requests in flight.
        do_reset();
        rdy_pct = 100; ord_pct = 0; lat_lo = 6; lat_hi = 6;
        for (int i = 0; i < 3; i++) begin begin_cycle(1'b0, 32'h0); end_cycle(); end
        begin_cycle(1'b1, 32'h103);
        chk("t3_no_req", 32'(bus_a.imem_req_valid), 0);
        end_cycle();
        begin_cycle(1'b0, 32'h0);
        chk("t3_stale", 32'(stale_a), 3);
        end_cycle();
        ord_pct = 100; seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            begin_cycle(1'b0, 32'h0);
            if (bus_a.out_valid) begin
                chk("t3_first_pc", bus_a.out_pc, 32'h100);
                chk("t3_first_instr", bus_a.out_instr, instr_of(32'h100));
                seen = 1;
            end
            end_cycle();
        end
        if (!seen) timeout_fail("t3_first");

        // Redirect coinciding with a response and a dequeue.
        do_reset();
        rdy_pct = 100; ord_pct = 100; lat_lo = 2; lat_hi = 2;
        for (int i = 0; i < 4; i++) begin begin_cycle(1'b0, 32'h0); end_cycle(); end
        begin_cycle(1'b1, 32'h200);
        chk("t4_ov_pre", 32'(bus_a.out_valid), 1);
        end_cycle();
        begin_cycle(1'b0, 32'h0);
        chk("t4_empty", 32'(bus_a.out_valid), 0);
        chk("t4_stale", 32'(stale_a), 1);
        end_cycle();

        // Random traffic against the queue model, with occasional resets.
        do_reset();
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 9000; i++) begin
            if (i % 1000 == 0) begin
                rdy_pct = $urandom_range(100, 30);
                ord_pct = $urandom_range(100, 20);
            end
            if ($urandom_range(499) == 0) do_reset();
            else begin
                tgt = $urandom;
                if ($urandom_range(7) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
                begin_cycle($urandom_range(99) < 3, tgt);
                end_cycle();
            end
        end

        // Narrow PC wraps from 0xFC to 0x00.
        reset_b = 1'b1;
        #3;
        @(posedge clk); #1;
        reset_b = 1'b0;
        fired_prev = 0; prev_addr = '0; got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            bus_b.imem_req_ready = 1'b1;
            bus_b.out_ready = 1'b1;
            bus_b.imem_resp_valid = fired_prev;
            bus_b.imem_resp_data = {24'h0, prev_addr} ^ 32'h5A00_0000;
            #3;
            if (bus_b.out_valid) begin
                chk("t5_pc", 32'(bus_b.out_pc), 32'(b_exp[got]));
                chk("t5_instr", bus_b.out_instr, {24'h0, b_exp[got]} ^ 32'h5A00_0000);
                got++;
            end
            fired_prev = bus_b.imem_req_valid && bus_b.imem_req_ready;
            prev_addr = bus_b.imem_req_addr;
            @(posedge clk); #1;
        end
        if (got < 4) timeout_fail("t5_wrap");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
